mandel_scheduler: RTL and testbench
===================================

// Module: mandel_scheduler
// PURPOSE
//  Frame-level sequencer for a bank of CORES mandelbrot iteration engines. It walks an H_RES x V_RES
//  pixel grid, generates a fixed-point (re,im) coordinate per pixel, and dispatches each pixel to an
//  idle engine. It collects iteration counts, possibly out of order, and streams (addr,iter) pixels
//  to the framebuffer writer over a valid/ready port. It sits between host frame config and the engines.
// PARAMETERS
//  CORES     4     number of mandelbrot engines served (1..16)
//  FP_WIDTH  25    fixed-point width of coordinates (matches engines)
//  FP_INT    4     integer bits of coordinates (informational; no arithmetic depends on it)
//  ITERW     8     width of engine iteration count
//  H_RES     320   pixels per line
//  V_RES     180   lines per frame
//  ADDRW     $clog2(H_RES*V_RES)  pixel address width
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 asynchronous reset, active low
//  frame_start  in   1                 start a frame; sampled only in IDLE
//  re_start     in   FP_WIDTH          re of pixel (0,0), signed
//  im_start     in   FP_WIDTH          im of pixel (0,0), signed
//  step         in   FP_WIDTH          coordinate increment per pixel/line, signed
//  busy         out  1                 frame in progress
//  frame_done   out  1                 one-cycle pulse when last pixel accepted
//  core_start   out  CORES             one-hot start pulse to engine k
//  core_re      out  FP_WIDTH          shared coordinate bus; valid in the cycle of core_start
//  core_im      out  FP_WIDTH          shared coordinate bus; valid in the cycle of core_start
//  core_done    in   CORES             engine k done pulse (1 cycle)
//  core_iter    in   CORES*ITERW       engine k iteration count, slice [k*ITERW+:ITERW], valid with done
//  pix_valid    out  1                 pixel result available
//  pix_ready    in   1                 downstream accepts pixel
//  pix_addr     out  ADDRW             y*H_RES+x of pixel
//  pix_iter     out  ITERW             iteration count of pixel
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; busy, frame_done, core_start, pix_valid=0; all slots free.
//   Reset mid-frame abandons the frame; no frame_done. In-flight engine results are dropped on return.
//  FSM: IDLE -(frame_start)-> RUN -(last pixel dispatched)-> DRAIN -(all slots free)-> IDLE + frame_done.
//   On frame_start: latch re_start/im_start/step; set x=y=0, re=re_start, im=im_start, addr=0; busy=1.
//   frame_start outside IDLE is ignored. frame_done is a 1-cycle pulse; busy falls in the same cycle.
//  Coordinate gen: per dispatch x++, re+=step. At x=H_RES-1: x=0, y++, re=re_start, im-=step.
//   Adds wrap modulo 2^FP_WIDTH, with no saturation. addr increments by 1 per dispatch.
//  Slot k per engine: FREE -> RUNNING (dispatch) -> PENDING (core_done latches iter) -> FREE (pix accepted).
//  Dispatch: at most one per cycle, in RUN only, to the lowest-index FREE slot. core_start[k] is high
//   for exactly one cycle, with core_re/core_im/addr tag registered in the same cycle.
//  Output: round-robin among PENDING slots, starting after the last granted slot. pix_valid/addr/iter
//   are held stable until pix_ready. A slot freed by acceptance is dispatchable no earlier than next cycle.
//  Simultaneous events: multiple core_done in one cycle all latch. Dispatch, done and accept on distinct
//   slots in the same cycle are all honoured. core_done on a non-RUNNING slot is ignored.
//  Latency: frame_start -> first core_start = 1 cycle; core_done -> pix_valid >= 1 cycle.
// CONFIGURATION
//  MANDEL_SCHED_PERF_EN defined: adds output frame_cycles [31:0], cleared at frame_start, +1 per cycle
//   while busy, held after frame_done. Also adds pix_stall [31:0], counting cycles with pix_valid&&!pix_ready.
//  Undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  mandel_pkg: slot_state_t enum {FREE,RUNNING,PENDING}, sched_state_t {IDLE,RUN,DRAIN}, and the
//   pix_t struct {addr,iter}.
//  Sub-module mandel_rr_arb (CORES-wide round-robin arbiter, req/grant one-hot) for output selection.
// TESTING (H_RES=4, V_RES=2, CORES=2, behavioural engines with configurable latency)
//  re_start=0, im_start=0, step=1 -> dispatch re seq 0,1,2,3,0,1,2,3; im seq 0,0,0,0,-1,-1,-1,-1
//   (all values in fixed-point units).
//  Engine0 latency 20, engine1 latency 3 -> pixels emerge out of order; all 8 addrs 0..7 appear exactly once.
//  Engine returns iter=addr; hold pix_ready=0 for 10 cycles -> pix_valid/addr/iter stable; no new dispatch.
//  Both engines done in the same cycle -> both results emitted, alternating grant; frame_done after addr 7.
//  Assert rst_n=0 mid-frame -> outputs 0 immediately; next frame_start runs a clean frame from addr 0.
//  frame_start pulsed while busy -> ignored; exactly one frame_done pulse occurs.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types for the mandelbrot frame scheduler.
//   slot_state_t  : per-engine slot lifecycle (FREE -> RUNNING -> PENDING -> FREE)
//   sched_state_t : frame sequencer states (IDLE -> RUN -> DRAIN -> IDLE)
//   pix_t         : pixel result payload {addr, iter}. It is sized for the largest supported
//                   configuration; users take the low ADDRW/ITERW bits.
package mandel_pkg;

    localparam int unsigned PIX_ADDRW = 32;
    localparam int unsigned PIX_ITERW = 16;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        RUNNING = 2'd1,
        PENDING = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [PIX_ADDRW-1:0] addr;
        logic [PIX_ITERW-1:0] iter;
    } pix_t;

endpackage

// File: rtl/mandel_rr_arb.sv
// N-wide round-robin arbiter. The search starts at the slot after the last grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : one bit per requester
//   grant_c    : one-hot grant (combinational); the priority pointer advances whenever it is non-zero
module mandel_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant_c
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] next_last_c;

    // Scan N positions starting at last+1 and take the first requester.
    always_comb begin
        int  idx;
        logic found;
        grant_c     = '0;
        next_last_c = last;
        found       = 1'b0;
        idx         = 0;
        for (int i = 1; i <= int'(N); i++) begin
            idx = (int'(last) + i) % int'(N);
            if (!found && req[IW'(idx)]) begin
                grant_c[IW'(idx)] = 1'b1;
                next_last_c       = IW'(idx);
                found             = 1'b1;
            end
        end
    end

    // Reset to the top slot so the first search begins at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(N - 1);
        end else if (|grant_c) begin
            last <= next_last_c;
        end
    end

endmodule

// File: rtl/mandel_scheduler.sv
// Frame-level sequencer for CORES mandelbrot engines: walks the H_RES x V_RES grid, dispatches one
// pixel coordinate per cycle to the lowest free engine, collects iteration counts (any order) and
// streams {addr, iter} results over a valid/ready port.
//   frame_start/re_start/im_start/step : frame configuration, sampled in IDLE
//   busy, frame_done                   : frame status (frame_done is a 1-cycle pulse)
//   core_start/core_re/core_im         : one-hot dispatch plus shared coordinate bus
//   core_done/core_iter                : per-engine completion and iteration count
//   pix_valid/pix_ready/pix_addr/pix_iter : result stream
// Optional macro MANDEL_SCHED_PERF_EN adds frame_cycles and pix_stall counters.
module mandel_scheduler
    import mandel_pkg::*;
#(
    parameter int unsigned CORES    = 4,
    parameter int unsigned FP_WIDTH = 25,
    parameter int unsigned FP_INT   = 4,
    parameter int unsigned ITERW    = 8,
    parameter int unsigned H_RES    = 320,
    parameter int unsigned V_RES    = 180,
    parameter int unsigned ADDRW    = $clog2(H_RES * V_RES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [FP_WIDTH-1:0]    re_start,
    input  logic [FP_WIDTH-1:0]    im_start,
    input  logic [FP_WIDTH-1:0]    step,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CORES-1:0]       core_start,
    output logic [FP_WIDTH-1:0]    core_re,
    output logic [FP_WIDTH-1:0]    core_im,
    input  logic [CORES-1:0]       core_done,
    input  logic [CORES*ITERW-1:0] core_iter,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [ADDRW-1:0]       pix_addr,
    output logic [ITERW-1:0]       pix_iter
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic [31:0]            frame_cycles,
    output logic [31:0]            pix_stall
`endif
);

    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned KW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(H_RES * V_RES - 1);
    localparam logic [XW-1:0]    LAST_X    = XW'(H_RES - 1);
    // Integer-bit count is informational only; no arithmetic depends on it.
    localparam int unsigned unused_fp_int = FP_INT;

    sched_state_t        state;
    slot_state_t         slot_st   [CORES];
    logic [ADDRW-1:0]    slot_addr [CORES];
    logic [ITERW-1:0]    slot_iter [CORES];
    logic [FP_WIDTH-1:0] re_base, step_q, re_cur, im_cur;
    logic [XW-1:0]       x;
    logic [ADDRW-1:0]    addr_cur;
    pix_t                out_q;
    logic [KW-1:0]       out_slot;

    logic                start_c, disp_c, accept_c, all_free_after_c;
    logic [CORES-1:0]    free_c, pend_req_c, grant_c;
    logic [KW-1:0]       disp_idx_c, grant_idx_c;
    logic [FP_WIDTH-1:0] re_c, im_c, base_c, step_c;
    logic [XW-1:0]       x_c;
    logic [ADDRW-1:0]    addr_c;
    logic                unused_bits;

    // Results are offered only while the output register is empty.
    mandel_rr_arb #(.N(CORES)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pend_req_c),
        .grant_c (grant_c)
    );

    // Dispatch selection; frame_start in IDLE dispatches pixel (0,0) straight from the inputs.
    always_comb begin
        start_c          = (state == IDLE) && frame_start;
        accept_c         = pix_valid && pix_ready;
        free_c           = '0;
        pend_req_c       = '0;
        disp_idx_c       = '0;
        grant_idx_c      = '0;
        all_free_after_c = 1'b1;
        for (int k = 0; k < int'(CORES); k++) begin
            free_c[k]     = (slot_st[k] == FREE);
            pend_req_c[k] = !pix_valid && (slot_st[k] == PENDING);
            if ((slot_st[k] != FREE) && !(accept_c && (out_slot == KW'(k)))) begin
                all_free_after_c = 1'b0;
            end
            if (grant_c[k]) begin
                grant_idx_c = KW'(k);
            end
        end
        for (int k = int'(CORES) - 1; k >= 0; k--) begin
            if (free_c[k]) begin
                disp_idx_c = KW'(k);
            end
        end
        disp_c = (start_c || (state == RUN)) && (|free_c);
        re_c   = start_c ? re_start : re_cur;
        im_c   = start_c ? im_start : im_cur;
        base_c = start_c ? re_start : re_base;
        step_c = start_c ? step     : step_q;
        x_c    = start_c ? '0       : x;
        addr_c = start_c ? '0       : addr_cur;
    end

    // Sequencer, coordinate generator, slot table and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            core_start <= '0;
            core_re    <= '0;
            core_im    <= '0;
            re_base    <= '0;
            step_q     <= '0;
            re_cur     <= '0;
            im_cur     <= '0;
            x          <= '0;
            addr_cur   <= '0;
            pix_valid  <= 1'b0;
            out_q      <= '0;
            out_slot   <= '0;
            for (int k = 0; k < int'(CORES); k++) begin
                slot_st[k]   <= FREE;
                slot_addr[k] <= '0;
                slot_iter[k] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            core_start <= '0;

            // Done pulses only count for slots that are actually waiting on an engine.
            for (int k = 0; k < int'(CORES); k++) begin
                if (core_done[k] && (slot_st[k] == RUNNING)) begin
                    slot_st[k]   <= PENDING;
                    slot_iter[k] <= core_iter[k*ITERW +: ITERW];
                end
            end

            if (accept_c) begin
                slot_st[out_slot] <= FREE;
                pix_valid         <= 1'b0;
            end

            if (|grant_c) begin
                pix_valid  <= 1'b1;
                out_q.addr <= PIX_ADDRW'(slot_addr[grant_idx_c]);
                out_q.iter <= PIX_ITERW'(slot_iter[grant_idx_c]);
                out_slot   <= grant_idx_c;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        re_base <= re_start;
                        step_q  <= step;
                    end
                end
                RUN: ;
                DRAIN: begin
                    if (all_free_after_c) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Dispatch after the state case so the last pixel's move to DRAIN takes effect.
            if (disp_c) begin
                core_start[disp_idx_c] <= 1'b1;
                core_re                <= re_c;
                core_im                <= im_c;
                slot_st[disp_idx_c]    <= RUNNING;
                slot_addr[disp_idx_c]  <= addr_c;
                addr_cur               <= addr_c + ADDRW'(1);
                if (x_c == LAST_X) begin
                    x      <= '0;
                    re_cur <= base_c;
                    im_cur <= im_c - step_c;
                end else begin
                    x      <= x_c + XW'(1);
                    re_cur <= re_c + step_c;
                    im_cur <= im_c;
                end
                if (addr_c == LAST_ADDR) begin
                    state <= DRAIN;
                end
            end
        end
    end

    assign pix_addr    = out_q.addr[ADDRW-1:0];
    assign pix_iter    = out_q.iter[ITERW-1:0];
    assign unused_bits = ^{out_q.addr[PIX_ADDRW-1:ADDRW], out_q.iter[PIX_ITERW-1:ITERW]};

`ifdef MANDEL_SCHED_PERF_EN
    // Frame cycle and output back-pressure counters, cleared when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cycles <= '0;
            pix_stall    <= '0;
        end else if (start_c) begin
            frame_cycles <= '0;
            pix_stall    <= '0;
        end else begin
            if (busy) begin
                frame_cycles <= frame_cycles + 32'd1;
            end
            if (pix_valid && !pix_ready) begin
                pix_stall <= pix_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mandel_scheduler.sv
`timescale 1ns/1ps
module tb_mandel_scheduler;

    localparam int unsigned CORES    = 2;
    localparam int unsigned FP_WIDTH = 25;
    localparam int unsigned ITERW    = 8;
    localparam int unsigned H_RES    = 4;
    localparam int unsigned V_RES    = 2;
    localparam int unsigned ADDRW    = 3;
    localparam int          NPIX     = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   frame_start;
    logic [FP_WIDTH-1:0]    re_start, im_start, step;
    logic                   busy, frame_done;
    logic [CORES-1:0]       core_start;
    logic [FP_WIDTH-1:0]    core_re, core_im;
    logic [CORES-1:0]       core_done;
    logic [CORES*ITERW-1:0] core_iter;
    logic                   pix_valid, pix_ready;
    logic [ADDRW-1:0]       pix_addr;
    logic [ITERW-1:0]       pix_iter;
`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0]            frame_cycles, pix_stall;
`endif

    always #5 clk = ~clk;

    mandel_scheduler #(
        .CORES(CORES), .FP_WIDTH(FP_WIDTH), .FP_INT(4), .ITERW(ITERW),
        .H_RES(H_RES), .V_RES(V_RES), .ADDRW(ADDRW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .re_start(re_start), .im_start(im_start), .step(step),
        .busy(busy), .frame_done(frame_done),
        .core_start(core_start), .core_re(core_re), .core_im(core_im),
        .core_done(core_done), .core_iter(core_iter),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_addr(pix_addr), .pix_iter(pix_iter)
`ifdef MANDEL_SCHED_PERF_EN
        , .frame_cycles(frame_cycles), .pix_stall(pix_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Behavioural engines: fixed latency per engine; iter = x + H_RES*y = re - H_RES*im for step=1.
    int lat     [CORES];
    int eng_cnt [CORES];
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done = '0;
            core_iter = '0;
            for (int k = 0; k < int'(CORES); k++) eng_cnt[k] = 0;
        end else begin
            for (int k = 0; k < int'(CORES); k++) begin
                int r, i;
                core_done[k] = 1'b0;
                if (eng_cnt[k] > 0) begin
                    eng_cnt[k]--;
                    if (eng_cnt[k] == 0) core_done[k] = 1'b1;
                end
                if (core_start[k]) begin
                    r = $signed(core_re);
                    i = $signed(core_im);
                    eng_cnt[k] = lat[k];
                    core_iter[k*ITERW +: ITERW] = ITERW'(r - int'(H_RES) * i);
                end
            end
        end
    end

    // Observation log, sampled mid-cycle.
    int disp_re[$];
    int disp_im[$];
    int acc_order[$];
    int seen_cnt  [NPIX];
    int seen_iter [NPIX];
    int done_cnt;
    int acc_at_done;
    int both_done;
    always @(negedge clk) begin
        if (core_start != '0) begin
            check("core_start onehot", 32'($onehot(core_start)), 1);
            disp_re.push_back($signed(core_re));
            disp_im.push_back($signed(core_im));
        end
        if (pix_valid && pix_ready) begin
            seen_cnt[pix_addr]++;
            seen_iter[pix_addr] = int'(pix_iter);
            acc_order.push_back(int'(pix_addr));
        end
        if (core_done == 2'b11) both_done++;
        if (frame_done) begin
            done_cnt++;
            acc_at_done = acc_order.size();
        end
    end

    task automatic clear_log();
        disp_re.delete();
        disp_im.delete();
        acc_order.delete();
        for (int a = 0; a < NPIX; a++) begin
            seen_cnt[a]  = 0;
            seen_iter[a] = -1;
        end
        done_cnt    = 0;
        acc_at_done = -1;
        both_done   = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " frame_done seen"}, 32'(done_cnt != 0), 1);
        repeat (2) tick();
    endtask

    task automatic check_frame(input string tag);
        for (int a = 0; a < NPIX; a++) begin
            check($sformatf("%s addr %0d count", tag, a), seen_cnt[a], 1);
            check($sformatf("%s addr %0d iter", tag, a), seen_iter[a], a);
        end
        check({tag, " frame_done pulses"}, done_cnt, 1);
        check({tag, " pixels before frame_done"}, acc_at_done, NPIX);
        check({tag, " busy after frame"}, 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_ready   = 1'b1;
        re_start    = '0;
        im_start    = '0;
        step        = FP_WIDTH'(1);
        lat[0]      = 3;
        lat[1]      = 3;
        clear_log();
        repeat (3) tick();
        check("reset busy", 32'(busy), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset core_start", 32'(core_start), 0);
        check("reset pix_valid", 32'(pix_valid), 0);
        rst_n = 1'b1;
        tick();

        // A: slow engine 0, fast engine 1 -> out-of-order results.
        lat[0] = 20;
        lat[1] = 3;
        clear_log();
        start_frame();
        check("A start latency core_start", 32'(core_start), 1);
        check("A start latency core_re", 32'(core_re), 0);
        wait_frame("A");
        check("A dispatch count", disp_re.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("A re[%0d]", i), (i < disp_re.size()) ? disp_re[i] : 32'hDEAD, i % 4);
            check($sformatf("A im[%0d]", i), (i < disp_im.size()) ? disp_im[i] : 32'hDEAD, -(i / 4));
        end
        check("A first accepted addr", (acc_order.size() > 0) ? acc_order[0] : -1, 1);
        check_frame("A");

        // B: downstream stall holds the output stable and blocks further dispatch.
        lat[0] = 2;
        lat[1] = 2;
        clear_log();
        pix_ready = 1'b0;
        start_frame();
        n = 0;
        while (!pix_valid && n < 100) begin
            tick();
            n++;
        end
        check("B pix_valid rises", 32'(pix_valid), 1);
        check("B first addr", 32'(pix_addr), 0);
        check("B first iter", 32'(pix_iter), 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("B hold %0d valid", c), 32'(pix_valid), 1);
            check($sformatf("B hold %0d addr", c), 32'(pix_addr), 0);
            check($sformatf("B hold %0d iter", c), 32'(pix_iter), 0);
        end
        check("B no dispatch during stall", disp_re.size(), 2);
        pix_ready = 1'b1;
        wait_frame("B");
        check_frame("B");

        // C: both engines finish in the same cycle; fresh reset gives a known arbiter pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        lat[0] = 3;
        lat[1] = 2;
        clear_log();
        start_frame();
        wait_frame("C");
        check("C simultaneous done seen", 32'(both_done > 0), 1);
        check("C first accepted", (acc_order.size() > 0) ? acc_order[0] : -1, 0);
        check("C second accepted", (acc_order.size() > 1) ? acc_order[1] : -1, 1);
        check_frame("C");

        // D: reset mid-frame, then a clean frame.
        lat[0] = 5;
        lat[1] = 5;
        clear_log();
        start_frame();
        repeat (4) tick();
        check("D busy before abort", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("D abort busy", 32'(busy), 0);
        check("D abort core_start", 32'(core_start), 0);
        check("D abort pix_valid", 32'(pix_valid), 0);
        check("D abort frame_done", 32'(frame_done), 0);
        repeat (3) tick();
        check("D no frame_done on abort", done_cnt, 0);
        rst_n = 1'b1;
        tick();
        lat[0] = 20;
        lat[1] = 3;
        clear_log();
        start_frame();
        check("D restart core_start", 32'(core_start), 1);
        check("D restart core_re", 32'(core_re), 0);
        check("D restart core_im", 32'(core_im), 0);
        wait_frame("D");
        check_frame("D");

        // E: frame_start while busy is ignored.
        lat[0] = 4;
        lat[1] = 4;
        clear_log();
        start_frame();
        repeat (3) tick();
        check("E busy at first extra pulse", 32'(busy), 1);
        start_frame();
        repeat (5) tick();
        check("E busy at second extra pulse", 32'(busy), 1);
        start_frame();
        wait_frame("E");
        repeat (30) tick();
        check("E single frame_done", done_cnt, 1);
        check("E dispatch count", disp_re.size(), NPIX);
        check("E idle afterwards", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
